// File: rtl/mix_columns_engine.sv
// Sequential AES MixColumns / InvMixColumns engine over a 128-bit state.
// Transforms COLS_PER_CYCLE columns per busy cycle behind valid/ready handshakes.
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);
    localparam logic [2:0] STEP     = 3'(COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [1:0]   r_col_idx;
    logic [127:0] r_work;
    logic         r_inv;
    logic         r_out_valid;

    logic [31:0]  w_col_mixed [4];
    logic [31:0]  w_col_next  [4];
    logic         w_col_sel   [4];
    logic [127:0] w_work_next;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Each output row r combines terms a,b,c,d taken from rows r, r+1, r+2, r+3.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  s   [4];
        logic [7:0]  x2  [4];
        logic [7:0]  x4  [4];
        logic [7:0]  x8  [4];
        logic [7:0]  m_a [4];
        logic [7:0]  m_b [4];
        logic [7:0]  m_c [4];
        logic [7:0]  m_d [4];
        logic [31:0] t;
        t = '0;
        for (int r = 0; r < 4; r++) begin
            s[r]  = col[31-8*r -: 8];
            x2[r] = xtime(s[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            if (inv) begin
                m_a[r] = x8[r] ^ x4[r] ^ x2[r];
                m_b[r] = x8[r] ^ x2[r] ^ s[r];
                m_c[r] = x8[r] ^ x4[r] ^ s[r];
                m_d[r] = x8[r] ^ s[r];
            end else begin
                m_a[r] = x2[r];
                m_b[r] = x2[r] ^ s[r];
                m_c[r] = s[r];
                m_d[r] = s[r];
            end
        end
        for (int r = 0; r < 4; r++) begin
            t[31-8*r -: 8] = m_a[r] ^ m_b[(r+1)%4] ^ m_c[(r+2)%4] ^ m_d[(r+3)%4];
        end
        return t;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign w_col_mixed[gi] = mix_col(r_work[127-32*gi -: 32], r_inv);
            assign w_col_sel[gi]   = (3'(gi) >= {1'b0, r_col_idx}) &&
                                     (3'(gi) <  ({1'b0, r_col_idx} + STEP));
            assign w_col_next[gi]  = w_col_sel[gi] ? w_col_mixed[gi] : r_work[127-32*gi -: 32];
        end
    endgenerate

    assign w_work_next = {w_col_next[0], w_col_next[1], w_col_next[2], w_col_next[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_col_idx   <= 2'd0;
            r_work      <= '0;
            r_inv       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work    <= in_state;
                        r_inv     <= in_inv;
                        r_col_idx <= 2'd0;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_work <= w_work_next;
                    if (r_col_idx == LAST_IDX) begin
                        r_col_idx   <= 2'd0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_col_idx <= r_col_idx + STEP[1:0];
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_state = r_work;

endmodule

// File: doc/mix_columns_engine.md
# mix_columns_engine

Sequential, parametrised AES MixColumns / InvMixColumns engine operating on a full 128-bit state. It replaces per-column combinational helpers in the round datapath: it accepts a state over a valid/ready handshake, transforms 1, 2 or 4 columns per cycle in either direction, and presents the result on a held output handshake. It sits between the ShiftRows/InvShiftRows stage and AddRoundKey in both the encryption and decryption round pipelines.

## Interface
- COLS_PER_CYCLE, 1, columns transformed per busy cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input state valid
- in_ready  out  1  engine can accept; high only in IDLE
- in_inv  in  1  0 = MixColumns, 1 = InvMixColumns; sampled with in_state
- in_state  in  128  column c = bits [127-32c -: 32]; byte r of a column = bits [31-8r -: 8]
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  downstream accepts
- out_state  out  128  transformed state, same byte layout as in_state

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, register in_state and in_inv, clear col_idx, go to BUSY.
  - BUSY: each cycle, transform columns col_idx..col_idx+COLS_PER_CYCLE-1 in place and advance col_idx by COLS_PER_CYCLE. After the last group, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Column order is 0 first (MSB end).
- Forward per column (s0..s3 to t0..t3):
  - t0 = 2s0^3s1^s2^s3, with rows rotating.
- Inverse per column:
  - t0 = 14s0^11s1^13s2^9s3, with rows rotating (t1 = 9s0^14s1^11s2^13s3, etc.).
- GF(2^8) arithmetic:
  - Multiplication uses xtime chains (modulus 0x11B), not lookup tables.
  - 9 = x8^x; 11 = x8^x2^x; 13 = x8^x4^x; 14 = x8^x4^x2.
- Mode is latched per transaction. Changing in_inv while BUSY or DONE has no effect.
- out_state is the working register and is stable throughout DONE.
- in_valid is ignored outside IDLE. No new transaction is accepted in the DONE→IDLE handshake cycle.

## Timing
- Reset (asynchronous, any state): FSM=IDLE, col_idx=0, working register=0, out_valid=0, out_state=0. in_ready is 1 once rst_n deasserts.
- Reset mid-transaction discards the state. No output is produced for it.
- Latency: out_valid rises N=4/COLS_PER_CYCLE cycles after the accepting edge (4, 2 or 1).
- Throughput: one state per N+2 cycles when out_ready is held high (1 IDLE + N BUSY + 1 DONE).
- Backpressure: out_valid stays high and out_state stays constant until the out_ready edge. It then drops on the next cycle.
- All outputs are registered except in_ready, which is decoded from the FSM state.

## Test plan
- **Forward, COLS_PER_CYCLE=1.** Stimulus: in_inv=0, in_state = db135345 f20a225c 01010101 2d26314c. Required: out_state = 8e4da1bc 9fdc589d 01010101 4d7ebdf8, out_valid 4 cycles after accept.
- **Inverse round-trip, each legal COLS_PER_CYCLE.** Stimulus: feed the previous output with in_inv=1. Required: original state returned; latency 4/2/1 cycles.
- **Fixed-point and carry columns.** Stimulus: in_state = c6c6c6c6 d4d4d4d5 00000000 01010101, forward. Required: c6c6c6c6 d5d5d7d6 00000000 01010101.
- **Backpressure.** Stimulus: hold out_ready=0 for 10 cycles after out_valid, toggle in_valid, in_inv and in_state meanwhile. Required: out_state unchanged, in_ready=0 throughout, a single handshake on out_ready, then in_ready=1 the next cycle.
- **Reset mid-BUSY (COLS_PER_CYCLE=1).** Stimulus: assert rst_n low at the 2nd BUSY cycle. Required: out_valid=0 and out_state=0 immediately; after release in_ready=1, and the next transaction is correct.
- **Back-to-back streaming.** Stimulus: 8 random states with alternating in_inv, out_ready tied high. Required: results match a golden model, in order, one per N+2 cycles.
